// File: rtl/mskkey_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : mskkey_bank_if
//  Description : Bus bundle for the masked key bank: load, refresh, randomness
//                and read channels. The master side drives requests, and the
//                slave side (the bank) returns status and key shares.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mskkey_bank_if #(
    parameter int d         = 2,
    parameter int Nbits     = 128,
    parameter int FEED_SIZE = 32,
    parameter int NSLOTS    = 4
);
    localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    logic                   load_start;
    logic [SW-1:0]          load_slot;
    logic [FEED_SIZE-1:0]   data_in;
    logic                   data_in_valid;
    logic                   data_in_ready;
    logic                   load_done;
    logic                   refresh_req;
    logic [SW-1:0]          refresh_slot;
    logic                   refresh_done;
    logic [(d-1)*Nbits-1:0] rnd;
    logic                   rnd_valid;
    logic                   rnd_ready;
    logic [SW-1:0]          rd_slot;
    logic                   key_used;
    logic [d*Nbits-1:0]     sharing_key;
    logic                   key_valid;
    logic                   busy;

    modport master (
        output load_start, load_slot, data_in, data_in_valid,
        output refresh_req, refresh_slot, rnd, rnd_valid, rd_slot, key_used,
        input  data_in_ready, load_done, refresh_done, rnd_ready,
        input  sharing_key, key_valid, busy
    );

    modport slave (
        input  load_start, load_slot, data_in, data_in_valid,
        input  refresh_req, refresh_slot, rnd, rnd_valid, rd_slot, key_used,
        output data_in_ready, load_done, refresh_done, rnd_ready,
        output sharing_key, key_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/mskkey_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mskkey_bank
//  Description : Bank of NSLOTS masked (d-share) keys. Keys are loaded in
//                FEED_SIZE chunks as a share-major sharing and can be
//                re-randomised by XOR with a fresh zero sharing. Reads are
//                presented bit-interleaved (share i of bit b at d*b+i).
//                Optional macro MSKKEY_AUTO_REFRESH_EN adds per-slot use
//                counters that trigger a refresh every RFRSH_PERIOD uses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mskkey_bank #(
    parameter int d            = 2,
    parameter int Nbits        = 128,
    parameter int FEED_SIZE    = 32,
    parameter int NSLOTS       = 4,
    parameter int RFRSH_PERIOD = 16
) (
    input  logic         clk,
    input  logic         rst,
    mskkey_bank_if.slave bus
);
    localparam int W      = d * Nbits;
    localparam int NCHUNK = W / FEED_SIZE;
    localparam int SW     = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        RND_WAIT = 2'd2,
        APPLY    = 2'd3
    } state_t;

    state_t              r_state;
    logic [SW-1:0]       r_tgt;
    logic [CW-1:0]       r_chunk;
    logic [NSLOTS-1:0]   r_valid;
    logic                r_load_done;
    logic                r_refresh_done;
    logic                r_din_ready;
    logic                r_rnd_ready;

    // Key storage and zero sharing are deliberately left unreset: the valid
    // flags mask their contents until a complete load has happened.
    logic [W-1:0]        r_slot [NSLOTS];
    logic [W-1:0]        r_zs;

    logic [W-1:0]        w_zs;
    logic [Nbits-1:0]    w_zs_sum;
    logic [W-1:0]        w_rd_word;
    logic [W-1:0]        w_sharing;
    logic                w_busy;
    logic                w_start_load;
    logic                w_start_rfsh;
    logic [SW-1:0]       w_rfsh_slot;
    logic                w_auto_req;
    logic [SW-1:0]       w_auto_slot;
    logic                w_load_acc;

    assign w_busy     = (r_state != IDLE);
    assign w_load_acc = (r_state == LOAD) && bus.data_in_valid;

    // Decode which operation (if any) starts this cycle; load beats refresh,
    // an external refresh beats an automatic one, invalid slots are ignored.
    always_comb begin
        w_start_load = (r_state == IDLE) && bus.load_start;
        w_rfsh_slot  = bus.refresh_req ? bus.refresh_slot : w_auto_slot;
        w_start_rfsh = (r_state == IDLE) && !bus.load_start &&
                       (bus.refresh_req ? r_valid[bus.refresh_slot] : w_auto_req);
    end

    // Control FSM with registered handshake and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_tgt          <= '0;
            r_chunk        <= '0;
            r_valid        <= '0;
            r_load_done    <= 1'b0;
            r_refresh_done <= 1'b0;
            r_din_ready    <= 1'b0;
            r_rnd_ready    <= 1'b0;
        end else begin
            r_load_done    <= 1'b0;
            r_refresh_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_load) begin
                        r_state                <= LOAD;
                        r_tgt                  <= bus.load_slot;
                        r_chunk                <= '0;
                        r_valid[bus.load_slot] <= 1'b0;
                        r_din_ready            <= 1'b1;
                    end else if (w_start_rfsh) begin
                        r_state     <= RND_WAIT;
                        r_tgt       <= w_rfsh_slot;
                        r_rnd_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.data_in_valid) begin
                        if (r_chunk == CW'(NCHUNK - 1)) begin
                            r_state        <= IDLE;
                            r_din_ready    <= 1'b0;
                            r_load_done    <= 1'b1;
                            r_valid[r_tgt] <= 1'b1;
                        end else begin
                            r_chunk <= r_chunk + CW'(1);
                        end
                    end
                end
                RND_WAIT: begin
                    if (bus.rnd_valid) begin
                        r_state     <= APPLY;
                        r_rnd_ready <= 1'b0;
                    end
                end
                APPLY: begin
                    r_state        <= IDLE;
                    r_refresh_done <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Zero sharing from fresh randomness: shares 1..d-1 are the random
    // chunks and share 0 their XOR, so all shares together XOR to zero.
    always_comb begin
        w_zs     = '0;
        w_zs_sum = '0;
        for (int i = 1; i < d; i++) begin
            w_zs[i*Nbits +: Nbits] = bus.rnd[(i-1)*Nbits +: Nbits];
            w_zs_sum               = w_zs_sum ^ bus.rnd[(i-1)*Nbits +: Nbits];
        end
        w_zs[Nbits-1:0] = w_zs_sum;
    end

    // Key datapath: shift in load chunks at the MSB, capture and apply masks.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_load_acc) begin
                r_slot[r_tgt] <= {bus.data_in, r_slot[r_tgt][W-1:FEED_SIZE]};
            end else if (r_state == APPLY) begin
                r_slot[r_tgt] <= r_slot[r_tgt] ^ r_zs;
            end
            if ((r_state == RND_WAIT) && bus.rnd_valid) begin
                r_zs <= w_zs;
            end
        end
    end

    // Convert the share-major slot word into the bit-interleaved read format.
    always_comb begin
        w_rd_word = r_slot[bus.rd_slot];
        w_sharing = '0;
        for (int b = 0; b < Nbits; b++) begin
            for (int i = 0; i < d; i++) begin
                w_sharing[d*b+i] = w_rd_word[i*Nbits+b];
            end
        end
    end

    assign bus.sharing_key   = w_sharing;
    assign bus.key_valid     = r_valid[bus.rd_slot] & ~(w_busy & (r_tgt == bus.rd_slot));
    assign bus.busy          = w_busy;
    assign bus.data_in_ready = r_din_ready;
    assign bus.rnd_ready     = r_rnd_ready;
    assign bus.load_done     = r_load_done;
    assign bus.refresh_done  = r_refresh_done;

`ifdef MSKKEY_AUTO_REFRESH_EN
    localparam int UW = (RFRSH_PERIOD > 1) ? $clog2(RFRSH_PERIOD) : 1;

    logic [UW-1:0]     r_use_cnt [NSLOTS];
    logic [NSLOTS-1:0] r_auto_pend;

    // Pick the lowest-numbered valid slot with a pending automatic refresh.
    always_comb begin
        w_auto_req  = 1'b0;
        w_auto_slot = '0;
        for (int s = NSLOTS - 1; s >= 0; s--) begin
            if (r_auto_pend[s] && r_valid[s]) begin
                w_auto_req  = 1'b1;
                w_auto_slot = SW'(s);
            end
        end
    end

    // Per-slot use counters; the last use of a period raises a pending
    // refresh, and starting a load or refresh of the slot restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NSLOTS; s++) begin
                r_use_cnt[s]   <= '0;
                r_auto_pend[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < NSLOTS; s++) begin
                if ((w_start_load && (bus.load_slot == SW'(s))) ||
                    (w_start_rfsh && (w_rfsh_slot == SW'(s)))) begin
                    r_use_cnt[s]   <= '0;
                    r_auto_pend[s] <= 1'b0;
                end else if (bus.key_used && (bus.rd_slot == SW'(s))) begin
                    if (r_use_cnt[s] == UW'(RFRSH_PERIOD - 1)) begin
                        r_use_cnt[s]   <= '0;
                        r_auto_pend[s] <= 1'b1;
                    end else begin
                        r_use_cnt[s] <= r_use_cnt[s] + UW'(1);
                    end
                end
            end
        end
    end
`else
    logic        w_unused_key_used;
    logic [31:0] w_unused_period;

    assign w_auto_req        = 1'b0;
    assign w_auto_slot       = '0;
    assign w_unused_key_used = bus.key_used;
    assign w_unused_period   = RFRSH_PERIOD;
`endif

endmodule
`default_nettype wire

// File: doc/mskkey_bank.md
MSKKEY_BANK -- requirements
Module: mskkey_bank

Interface
REQ-001 Parameters SHALL be: d, 2, number of shares; Nbits, 128, key bits; FEED_SIZE, 32, load chunk width; NSLOTS, 4, key slots; RFRSH_PERIOD, 16, key uses between automatic refreshes.
REQ-002 Port: clk  in  1  single clock, all logic on rising edge.
REQ-003 Port: rst  in  1  synchronous reset, active low.
REQ-004 Port: load_start  in  1  start loading slot load_slot; load_slot  in  clog2(NSLOTS)  target slot.
REQ-005 Port: data_in  in  FEED_SIZE  key-sharing chunk; data_in_valid  in  1; data_in_ready  out  1.
REQ-006 Port: load_done  out  1  one-cycle pulse, load complete.
REQ-007 Port: refresh_req  in  1; refresh_slot  in  clog2(NSLOTS); refresh_done  out  1  one-cycle pulse.
REQ-008 Port: rnd  in  (d-1)*Nbits  fresh randomness; rnd_valid  in  1; rnd_ready  out  1.
REQ-009 Port: rd_slot  in  clog2(NSLOTS); key_used  in  1  one-cycle pulse per key consumption.
REQ-010 Port: sharing_key  out  d*Nbits  sharing of slot rd_slot, bit-interleaved (share i of bit b at index d*b+i).
REQ-011 Port: key_valid  out  1; busy  out  1  FSM not IDLE.

Function
REQ-012 d*Nbits SHALL be a multiple of FEED_SIZE; NCHUNK = d*Nbits/FEED_SIZE.
REQ-013 FSM states SHALL be IDLE, LOAD, RND_WAIT, APPLY.
REQ-014 IDLE + load_start -> LOAD, slot latched, chunk counter = 0, slot valid flag cleared; load_start SHALL win over simultaneous refresh_req.
REQ-015 IDLE + refresh_req (no load_start) -> RND_WAIT, refresh_slot latched; request to a slot with cleared valid flag SHALL be ignored.
REQ-016 Requests outside IDLE SHALL be ignored (no queuing).
REQ-017 data_in_ready SHALL equal 1 exactly in LOAD; each accepted chunk shifts the slot share-major register right by FEED_SIZE, chunk entering at MSB (first chunk ends at LSB).
REQ-018 On the NCHUNK-th accepted chunk: next cycle load_done=1, slot valid flag set, FSM -> IDLE.
REQ-019 rnd_ready SHALL equal 1 exactly in RND_WAIT; on rnd_valid the zero sharing (share i>=1 = rnd chunk i-1, share 0 = XOR of all chunks) SHALL be registered, FSM -> APPLY.
REQ-020 APPLY (one cycle): slot <= slot XOR zero sharing; next cycle refresh_done=1, FSM -> IDLE; unshared key value SHALL be unchanged.
REQ-021 key_valid SHALL equal valid flag of rd_slot AND NOT (FSM in LOAD/RND_WAIT/APPLY targeting rd_slot); combinational on rd_slot.
REQ-022 Refresh latency SHALL be: request cycle, >=1 RND_WAIT cycle, APPLY, done pulse -- min 3 cycles req to refresh_done.
REQ-023 Reads of slots not being updated SHALL remain valid and stable throughout any operation.

Reset
REQ-024 rst=0 at a clock edge SHALL set FSM IDLE, all valid flags 0, chunk counter 0, use counters 0, load_done/refresh_done 0, data_in_ready/rnd_ready 0.
REQ-025 Key slot and zero-sharing registers SHALL NOT be reset (contents undefined but masked); reset mid-LOAD leaves that slot invalid.

Configuration
REQ-026 Macro MSKKEY_AUTO_REFRESH_EN: when defined, per-slot counter increments on key_used for rd_slot; on reaching RFRSH_PERIOD it clears and raises an internal refresh request for that slot, served like refresh_req with external refresh_req having priority; counter cleared on load and refresh.
REQ-027 Without MSKKEY_AUTO_REFRESH_EN: no counters, key_used ignored, refresh only via refresh_req.

Verification
REQ-028 d=2, Nbits=128, FEED=32: load slot 1 with 8 chunks -> load_done 1 cycle after 8th accept, key_valid=1 for rd_slot=1, XOR of shares equals loaded key.
REQ-029 Load with data_in_valid toggling every other cycle -> same contents, load_done after 8th accepted chunk only.
REQ-030 Refresh slot 1, rnd_valid delayed 5 cycles -> rnd_ready high 5 cycles, shares change, unmasked key unchanged, refresh_done pulse once.
REQ-031 load_start and refresh_req same cycle -> LOAD entered, refresh ignored; refresh_req to invalid slot -> busy stays 0.
REQ-032 rst=0 mid-LOAD after 3 chunks -> busy=0, key_valid=0 for that slot, data_in_ready=0.
REQ-033 With MSKKEY_AUTO_REFRESH_EN, RFRSH_PERIOD=16: 16 key_used pulses on slot 0 -> rnd_ready asserts, refresh_done follows; without macro -> no refresh.
